fdiv_stream: RTL

- Parametrised, flow-controlled successor to the fixed-latency single-precision divider.
- Wraps the existing reciprocal (finv, 3 stages) and multiplier (fmul, 2 stages) datapath with per-entry valid, a tag and a mode bit.
- Handles divide-by-zero in front of the datapath and adds a credit-protected output FIFO, so a downstream consumer can apply backpressure without losing results.
- Sits between the FPU issue logic and the writeback arbiter.

---
 rtl/fpu_pkg.sv | 16 +
 rtl/fdiv_core.sv | 43 ++++
 rtl/finv.sv | 27 ++
 rtl/fmul.sv | 30 +++
 rtl/fdiv_stream.sv | 69 ++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: FP32 constants, zero test and the divider sideband carried down the pipe
package fpu_pkg;
  localparam logic [31:0] ONE = 32'h3f800000;
  localparam logic [31:0] QNAN = 32'h7fc00000;
  localparam logic [7:0] EXP_MAX = 8'hff;
  localparam int FDIV_CORE_LAT = 6;
  localparam int FDIV_TAG_MAX = 16;
  typedef struct packed {
    logic [FDIV_TAG_MAX-1:0] tag;
    logic dz;
    logic [31:0] dz_y;
  } fdiv_side_t;
  function automatic logic fp_is_zero(input logic [31:0] x);
    return (x & 32'h7f800000) == 32'd0;
  endfunction
endpackage

// File: rtl/fdiv_core.sv
// fdiv_core: x1 * finv(x2) with valid/sideband aligned to LAT, divide-by-zero override at the end
module fdiv_core #(
  parameter int TAG_W = 4,
  parameter int LAT = fpu_pkg::FDIV_CORE_LAT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [31:0]       x1,
  input  logic [31:0]       x2,
  input  fpu_pkg::fdiv_side_t side,
  output logic              out_valid,
  output logic [31:0]       y,
  output logic [TAG_W-1:0]  tag,
  output logic              ovf,
  output logic              dz
);
  import fpu_pkg::*;
  logic [31:0] x1_q, x2_q, x1_d1, x1_d2, x1_d3, inv_y, mul_y;
  logic        mul_ovf;
  logic [LAT-1:0] v_q;
  fdiv_side_t  sd_q [LAT];
  always_ff @(posedge clk) begin
    x1_q <= x1;
    x2_q <= x2;
    x1_d1 <= x1_q;
    x1_d2 <= x1_d1;
    x1_d3 <= x1_d2;
    sd_q[0] <= side;
    for (int i = 1; i < LAT; i++) sd_q[i] <= sd_q[i-1];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) v_q <= '0;
    else v_q <= {v_q[LAT-2:0], in_valid};
  // x1 waits three edges so it meets the reciprocal at the multiplier
  finv u_finv (.clk(clk), .x(x2_q), .y(inv_y));
  fmul u_fmul (.clk(clk), .a(x1_d3), .b(inv_y), .y(mul_y), .ovf(mul_ovf));
  assign out_valid = v_q[LAT-1];
  assign y = sd_q[LAT-1].dz ? sd_q[LAT-1].dz_y : mul_y;
  assign ovf = !sd_q[LAT-1].dz && mul_ovf;
  assign dz = sd_q[LAT-1].dz;
  assign tag = sd_q[LAT-1].tag[TAG_W-1:0];
endmodule

// File: rtl/finv.sv
// finv: 3-stage FP32 reciprocal, truncating, denormal results flushed to zero
module finv (
  input  logic        clk,
  input  logic [31:0] x,
  output logic [31:0] y
);
  import fpu_pkg::*;
  logic [31:0] x_q;
  logic        s_q;
  logic [7:0]  e_q;
  logic        exact_q;
  logic [22:0] q_q;
  logic [22:0] q;
  logic [9:0]  er;
  assign q = 23'(48'h8000_0000_0000 / {24'd0, 1'b1, x_q[22:0]});
  assign er = (exact_q ? 10'd254 : 10'd253) - {2'b0, e_q};
  always_ff @(posedge clk) begin
    x_q <= x;
    s_q <= x_q[31];
    e_q <= x_q[30:23];
    exact_q <= x_q[22:0] == 23'd0;
    q_q <= q;
    y <= e_q == 8'd0 ? {s_q, EXP_MAX, 23'd0} :
         (er[9] || er == 10'd0) ? {s_q, 31'd0} :
         {s_q, er[7:0], exact_q ? 23'd0 : q_q};
  end
endmodule

// File: rtl/fmul.sv
// fmul: 2-stage FP32 multiplier, truncating, flags exponent overflow
module fmul (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        ovf
);
  import fpu_pkg::*;
  logic        s_q;
  logic        z_q;
  logic [9:0]  e_q;
  logic [24:0] p_q;
  logic [9:0]  e;
  logic [22:0] frac;
  logic        zero;
  logic        big;
  assign e = e_q + {9'd0, p_q[24]};
  assign frac = p_q[24] ? p_q[23:1] : p_q[22:0];
  assign zero = z_q || e[9] || e == 10'd0;
  assign big = !zero && e >= 10'd255;
  always_ff @(posedge clk) begin
    s_q <= a[31] ^ b[31];
    z_q <= fp_is_zero(a) | fp_is_zero(b);
    e_q <= {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    p_q <= 25'(({24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]}) >> 23);
    y <= zero ? {s_q, 31'd0} : big ? {s_q, EXP_MAX, 23'd0} : {s_q, e[7:0], frac};
    ovf <= big;
  end
endmodule

// File: rtl/fdiv_stream.sv
// fdiv_stream: flow-controlled FP32 divider; credits cover in-flight plus buffered results
module fdiv_stream #(
  parameter int TAG_W = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CORE_LAT = fpu_pkg::FDIV_CORE_LAT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             out_dz
);
  import fpu_pkg::*;
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [31:0]      x1, c_y;
  logic             accept, pop, c_valid, c_ovf, c_dz;
  logic [TAG_W-1:0] c_tag;
  fdiv_side_t       side;
  logic [AW:0]      reserved, wr_ptr, rd_ptr;
  logic [31:0]      mem_y [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];
  logic             mem_ovf [FIFO_DEPTH];
  logic             mem_dz [FIFO_DEPTH];
  assign x1 = in_op ? ONE : in_x1;
  always_comb begin
    side.tag = FDIV_TAG_MAX'(in_tag);
    side.dz = fp_is_zero(in_x2);
    side.dz_y = fp_is_zero(x1) ? QNAN : {x1[31] ^ in_x2[31], EXP_MAX, 23'd0};
  end
  // depth is a power of two, so the counter MSB alone means "no credit left"
  assign in_ready = !reserved[AW];
  assign accept = in_valid && in_ready;
  assign out_valid = wr_ptr != rd_ptr;
  assign pop = out_valid && out_ready;
  fdiv_core #(.TAG_W(TAG_W), .LAT(CORE_LAT)) u_core (
    .clk(clk), .rstn(rstn), .in_valid(accept), .x1(x1), .x2(in_x2), .side(side),
    .out_valid(c_valid), .y(c_y), .tag(c_tag), .ovf(c_ovf), .dz(c_dz)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      reserved <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      reserved <= reserved + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
      wr_ptr <= wr_ptr + {{AW{1'b0}}, c_valid};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (c_valid) begin
      mem_y[wr_ptr[AW-1:0]] <= c_y;
      mem_tag[wr_ptr[AW-1:0]] <= c_tag;
      mem_ovf[wr_ptr[AW-1:0]] <= c_ovf;
      mem_dz[wr_ptr[AW-1:0]] <= c_dz;
    end
  assign out_y = out_valid ? mem_y[rd_ptr[AW-1:0]] : 32'd0;
  assign out_tag = out_valid ? mem_tag[rd_ptr[AW-1:0]] : '0;
  assign out_ovf = out_valid && mem_ovf[rd_ptr[AW-1:0]];
  assign out_dz = out_valid && mem_dz[rd_ptr[AW-1:0]];
endmodule
